pipe_in_word_decoder: RTL and testbench
=======================================

Name: pipe_in_word_decoder

Overview:
- Sits directly downstream of the host pipe-in FIFO (endpoint 0x80) inside the host core.
- Consumes the 32-bit downstream word stream from the PC and classifies each word as a register write, a NOP or part of a routed packet.
- Register writes go to a 32x16 configuration register file; packets are reassembled into {route, payload} beats for the router.

Parameters:
- NUM_REGS, 32, number of configuration registers; reg_id width is clog2(NUM_REGS)=5.
- REG_W, 16, configuration register width.
- ROUTE_W, 10, route field width.
- RESET_REG_DEFAULT, 16'h0003, reset value of register 31 (bit0 pReset, bit1 sReset asserted); all other registers reset to 0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- in_data  in  32  downstream word from pipe-in FIFO.
- in_valid  in  1  in_data valid.
- in_ready  out  1  decoder accepts in_data this cycle.
- conf_regs  out  NUM_REGS*REG_W  flattened register file; reg k at bits [k*16+15:k*16].
- conf_wr  out  1  one-cycle pulse when a register is written.
- conf_wr_id  out  5  id of the register written (valid with conf_wr).
- pkt_valid  out  1  packet beat valid.
- pkt_ready  in  1  downstream accepts packet beat.
- pkt_route  out  ROUTE_W  packet route.
- pkt_payload  out  32  packet payload.
- route_err_cnt  out  8  saturating count of route words with nonzero bits [31:10].

Behaviour:
- Transfer occurs on in_valid && in_ready; pkt transfer occurs on pkt_valid && pkt_ready.
- Reset (reset_n=0 at a clk edge): state=IDLE; pkt_valid=0; pkt_route=0; pkt_payload=0; conf_wr=0; conf_wr_id=0; route_err_cnt=0; regs 0..30=0; reg31=RESET_REG_DEFAULT.
  - Reset mid-packet discards the held payload.
  - Any pending pkt beat is dropped.
- FSM states: IDLE, WAIT_ROUTE.
- IDLE, accepted word with [31:30]==2'b10 (command):
  - [29]==0: register write, reg_id=[28:24], data=[15:0]; bits [23:16] ignored. Register updated at the next edge. conf_wr=1 and conf_wr_id=reg_id in the cycle after acceptance (1-cycle latency).
  - [29]==1: NOP (e.g. 0xBF000001); discarded, no side effects.
  - State stays IDLE.
- IDLE, accepted word with [31:30]!=2'b10: latched as the payload; go to WAIT_ROUTE.
- WAIT_ROUTE, any accepted word is the route word:
  - pkt_route=[9:0], pkt_payload=held payload, pkt_valid=1 from the next cycle (1-cycle latency).
  - Go to IDLE.
  - If [31:10]!=0, increment route_err_cnt (saturate at 255); the packet is still emitted.
- in_ready:
  - 1 in IDLE.
  - In WAIT_ROUTE, in_ready = !pkt_valid || pkt_ready, so a route word is accepted in the same cycle an old beat drains. No bubble; back-to-back packets at 1 word/cycle.
- pkt_valid is held with stable route/payload until pkt_ready; it never drops without a handshake.
- Commands and payload words in IDLE are accepted while a previous beat is stalled; only the route word back-pressures.
- Simultaneous pkt handshake and new route word: the output register reloads and pkt_valid stays 1.
- conf_wr deasserts in the cycle after its pulse unless another write is accepted back-to-back. Consecutive writes give consecutive pulses.
- Register 31 is an ordinary register; its bits drive resets elsewhere, and the decoder itself is not reset by them.

Decomposition:
- Shared package (host_pkg) holds:
  - constants CMD_TAG=2'b10, NOP_WORD=32'hBF000001, RESET_REG_ID=5'd31;
  - a typedef for the command word {tag[1:0], is_nop, reg_id[4:0], rsvd[7:0], data[15:0]};
  - typedef pkt_t {route[9:0], payload[31:0]}.
- One sub-module, conf_reg_file: the 32x16 registers, write port (wr_en, wr_id, wr_data), per-register reset defaults and the flattened output.

Test Plan:
- Reset release:
  - conf_regs all 0 except reg31=16'h0003.
  - in_ready=1, pkt_valid=0, route_err_cnt=0.
- Command word 0x9F00_0000 (SetReg 31,0):
  - next cycle conf_wr=1, conf_wr_id=31;
  - reg31=0; other regs unchanged.
- Words 0x4C70F07C then 0x00000003 with pkt_ready=1:
  - one beat route=3, payload=0x4C70F07C, one cycle after the route word;
  - route_err_cnt=0.
- Two packets back-to-back, pkt_ready=0 for 5 cycles after the first beat:
  - in_ready=0 when the second route word is presented;
  - first beat held stable;
  - on release both beats arrive in order with no loss.
- 14 NOPs 0xBF000001: no conf_wr, no pkt_valid, state remains IDLE.
- Route word 0x00400005:
  - packet emitted with route=5;
  - route_err_cnt increments to 1; after 300 such words it reads 255.
- Reset asserted in WAIT_ROUTE:
  - held payload discarded;
  - a subsequent route-like word 0x00000002 is treated as a payload, not emitted as a packet.

Source files
------------

// File: rtl/host_pkg.sv
// Shared definitions for the host pipe-in word decoder.
// Holds register-file sizing, the command word layout, the packet beat
// layout and the decoder state encoding.
package host_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W = 16;
  localparam int REG_ID_W = $clog2(NUM_REGS);
  localparam int ROUTE_W = 10;
  localparam logic [REG_W-1:0] RESET_REG_DEFAULT = 16'h0003;

  localparam logic [1:0] CMD_TAG = 2'b10;
  localparam logic [31:0] NOP_WORD = 32'hBF000001;
  localparam logic [REG_ID_W-1:0] RESET_REG_ID = 5'd31;

  typedef struct packed {
    logic [1:0] tag;
    logic is_nop;
    logic [REG_ID_W-1:0] reg_id;
    logic [7:0] rsvd;
    logic [REG_W-1:0] data;
  } cmd_word_t;

  typedef struct packed {
    logic [ROUTE_W-1:0] route;
    logic [31:0] payload;
  } pkt_t;

  typedef enum logic {
    IDLE,
    WAIT_ROUTE
  } state_t;

endpackage

// File: rtl/pipe_in_word_decoder_if.sv
// Stream bundle around the decoder.
//   in_data/in_valid/in_ready : word stream from the pipe-in FIFO
//   pkt_valid/pkt_ready/pkt_route/pkt_payload : reassembled packet beats
// slave = decoder side, master = FIFO/router (or testbench) side.
interface pipe_in_word_decoder_if;
  import host_pkg::*;

  logic [31:0] in_data;
  logic in_valid;
  logic in_ready;
  logic pkt_valid;
  logic pkt_ready;
  logic [ROUTE_W-1:0] pkt_route;
  logic [31:0] pkt_payload;

  modport master (
    output in_data, in_valid, pkt_ready,
    input in_ready, pkt_valid, pkt_route, pkt_payload
  );

  modport slave (
    input in_data, in_valid, pkt_ready,
    output in_ready, pkt_valid, pkt_route, pkt_payload
  );

endinterface

// File: rtl/pipe_in_word_decoder_conf_reg_file.sv
// Configuration register file, NUM_REGS x REG_W.
//   clk, reset_n : clock, synchronous active-low reset
//   wr_en, wr_id, wr_data : single write port, takes effect at the clock edge
//   conf_regs : flattened contents, reg k at [k*REG_W +: REG_W]
// Register RESET_REG_ID resets to RESET_REG_DEFAULT, all others to zero.
module conf_reg_file
  import host_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic wr_en,
  input  logic [REG_ID_W-1:0] wr_id,
  input  logic [REG_W-1:0] wr_data,
  output logic [NUM_REGS*REG_W-1:0] conf_regs
);

  logic [REG_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= (k == int'(RESET_REG_ID)) ? RESET_REG_DEFAULT : '0;
      end
    end else if (wr_en) begin
      regs_q[wr_id] <= wr_data;
    end
  end

  always_comb begin
    conf_regs = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      conf_regs[k*REG_W +: REG_W] = regs_q[k];
    end
  end

endmodule

// File: rtl/pipe_in_word_decoder.sv
// Pipe-in word decoder: classifies downstream words as register writes,
// NOPs or packet words and reassembles packets into {route, payload} beats.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave) : input word stream and output packet beat stream
//   conf_regs : flattened configuration register file
//   conf_wr, conf_wr_id : one-cycle pulse and id of a register write
//   route_err_cnt : saturating count of route words with bits [31:10] set
//
// state      | meaning
// IDLE       | expecting a command or the payload word of a packet
// WAIT_ROUTE | payload held, next accepted word is its route word
module pipe_in_word_decoder
  import host_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  pipe_in_word_decoder_if.slave bus,
  output logic [NUM_REGS*REG_W-1:0] conf_regs,
  output logic conf_wr,
  output logic [REG_ID_W-1:0] conf_wr_id,
  output logic [7:0] route_err_cnt
);

  state_t state_q, state_d;
  cmd_word_t cmd;
  logic [31:0] payload_q;
  pkt_t pkt_q;
  logic pkt_valid_q;
  logic in_ready;
  logic accept;
  logic wr_en;
  logic load_payload;
  logic load_pkt;
  logic route_err;

  assign cmd = cmd_word_t'(bus.in_data);
  assign route_err = |bus.in_data[31:ROUTE_W];

  // Only the route word can be blocked: it needs the output register, which
  // frees up in the same cycle the held beat is taken.
  assign in_ready = (state_q == IDLE) || !pkt_valid_q || bus.pkt_ready;
  assign accept = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    wr_en = 1'b0;
    load_payload = 1'b0;
    load_pkt = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd.tag == CMD_TAG) begin
            wr_en = !cmd.is_nop;
          end else begin
            load_payload = 1'b1;
            state_d = WAIT_ROUTE;
          end
        end
      end
      WAIT_ROUTE: begin
        if (accept) begin
          load_pkt = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      payload_q <= '0;
      pkt_q <= '0;
      pkt_valid_q <= 1'b0;
      conf_wr <= 1'b0;
      conf_wr_id <= '0;
      route_err_cnt <= '0;
    end else begin
      state_q <= state_d;
      conf_wr <= wr_en;
      if (wr_en) begin
        conf_wr_id <= cmd.reg_id;
      end
      if (load_payload) begin
        payload_q <= bus.in_data;
      end
      if (load_pkt) begin
        pkt_q <= '{route: bus.in_data[ROUTE_W-1:0], payload: payload_q};
        pkt_valid_q <= 1'b1;
        if (route_err && route_err_cnt != 8'hFF) begin
          route_err_cnt <= route_err_cnt + 8'd1;
        end
      end else if (bus.pkt_ready) begin
        pkt_valid_q <= 1'b0;
      end
    end
  end

  conf_reg_file u_conf_reg_file (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_id    (cmd.reg_id),
    .wr_data  (cmd.data),
    .conf_regs(conf_regs)
  );

  assign bus.in_ready = in_ready;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_route = pkt_q.route;
  assign bus.pkt_payload = pkt_q.payload;

endmodule

// File: tb/tb_pipe_in_word_decoder.sv
module tb_pipe_in_word_decoder;
  import host_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NUM_REGS*REG_W-1:0] conf_regs;
  logic conf_wr;
  logic [REG_ID_W-1:0] conf_wr_id;
  logic [7:0] route_err_cnt;

  pipe_in_word_decoder_if bus ();

  pipe_in_word_decoder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .conf_regs    (conf_regs),
    .conf_wr      (conf_wr),
    .conf_wr_id   (conf_wr_id),
    .route_err_cnt(route_err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: what the decoder should look like right now.
  logic [REG_W-1:0] m_regs [NUM_REGS];
  logic m_wait;        // payload word received, route word outstanding
  logic [31:0] m_payload;
  logic m_pend;        // a beat is being presented
  logic m_wr;          // conf_wr pulse expected
  int m_cnt;
  pkt_t beat_q[$];
  logic [REG_ID_W-1:0] wr_q[$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void chk_regs(logic [NUM_REGS*REG_W-1:0] act);
    logic [NUM_REGS*REG_W-1:0] exp;
    for (int k = 0; k < NUM_REGS; k++) exp[k*REG_W +: REG_W] = m_regs[k];
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL conf_regs: got %h expected %h", act, exp);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event happened, none expected", nm);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
    m_regs[31] = 16'h0003;
    m_wait = 1'b0;
    m_payload = '0;
    m_pend = 1'b0;
    m_wr = 1'b0;
    m_cnt = 0;
    beat_q.delete();
    wr_q.delete();
  endfunction

  // One clock cycle of stimulus; checks the observable state first, then
  // advances the model by what the coming edge must do.
  task automatic cycle(input logic [31:0] w, input logic v, input logic rdy, output logic acc);
    logic exp_rdy;
    logic new_beat;
    @(negedge clk);
    #1;
    bus.in_data = w;
    bus.in_valid = v;
    bus.pkt_ready = rdy;
    #1;
    exp_rdy = !m_wait || !m_pend || rdy;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("pkt_valid", 64'(bus.pkt_valid), 64'(m_pend));
    chk("conf_wr", 64'(conf_wr), 64'(m_wr));
    chk("route_err_cnt", 64'(route_err_cnt), 64'(m_cnt));
    chk_regs(conf_regs);
    acc = v && exp_rdy;
    new_beat = 1'b0;
    m_wr = 1'b0;
    if (acc) begin
      if (!m_wait) begin
        if (w[31:30] == 2'b10) begin
          if (!w[29]) begin
            m_wr = 1'b1;
            wr_q.push_back(w[28:24]);
            m_regs[w[28:24]] = w[15:0];
          end
        end else begin
          m_payload = w;
          m_wait = 1'b1;
        end
      end else begin
        beat_q.push_back('{route: w[9:0], payload: m_payload});
        new_beat = 1'b1;
        m_wait = 1'b0;
        if ((w >> 10) != 0 && m_cnt < 255) m_cnt++;
      end
    end
    m_pend = new_beat || (m_pend && !rdy);
  endtask

  task automatic send(input logic [31:0] w, input logic rdy);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      cycle(w, 1'b1, rdy, acc);
      n++;
    end
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic idle(input int n, input logic rdy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(32'h0, 1'b0, rdy, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.pkt_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_pkt_route", 64'(bus.pkt_route), 64'(0));
    chk("rst_pkt_payload", 64'(bus.pkt_payload), 64'(0));
    chk("rst_conf_wr_id", 64'(conf_wr_id), 64'(0));
    reset_n = 1'b1;
  endtask

  // Monitor: sampled after the driver has settled this cycle's inputs, so
  // pkt_valid && pkt_ready here is exactly the handshake of the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset_n) begin
        if (conf_wr) begin
          if (wr_q.size() == 0) fail_now("conf_wr_unexpected");
          else chk("conf_wr_id", 64'(conf_wr_id), 64'(wr_q.pop_front()));
        end
        if (bus.pkt_valid) begin
          if (beat_q.size() == 0) begin
            fail_now("pkt_unexpected");
          end else begin
            chk("pkt_route", 64'(bus.pkt_route), 64'(beat_q[0].route));
            chk("pkt_payload", 64'(bus.pkt_payload), 64'(beat_q[0].payload));
            if (bus.pkt_ready) void'(beat_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, run incomplete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [31:0] w;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.pkt_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    idle(2, 1'b1);

    // SetReg 31 <= 0
    send(32'h9F00_0000, 1'b1);
    idle(2, 1'b1);

    // single packet
    send(32'h4C70_F07C, 1'b1);
    send(32'h0000_0003, 1'b1);
    idle(2, 1'b1);

    // back-to-back packets with a stalled first beat
    send(32'h1111_0001, 1'b1);
    send(32'h0000_0011, 1'b1);
    send(32'h2222_0002, 1'b0);
    for (int i = 0; i < 4; i++) cycle(32'h0000_0022, 1'b1, 1'b0, acc);
    send(32'h0000_0022, 1'b1);
    idle(3, 1'b1);

    // NOPs, including while a beat is stalled
    for (int i = 0; i < 14; i++) send(NOP_WORD, 1'b1);
    send(32'h3333_0003, 1'b1);
    send(32'h0000_0033, 1'b0);
    send(NOP_WORD, 1'b0);
    send(32'h8500_ABCD, 1'b0);
    idle(2, 1'b1);

    // route error counter and saturation
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(32'h1234_0000 | i, 1'b1);
      send(32'h0040_0005, 1'b1);
    end
    idle(2, 1'b1);
    chk("err_saturated", 64'(route_err_cnt), 64'(255));

    // reset while waiting for the route word
    do_reset();
    send(32'h0ABC_DEF0, 1'b1);
    do_reset();
    send(32'h0000_0002, 1'b1);
    idle(2, 1'b1);
    send(32'h0000_0007, 1'b1);
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1: w = {2'b10, 1'b0, 5'($urandom_range(0, 31)), 8'($urandom), 16'($urandom)};
        2: w = ($urandom_range(0, 1) == 0) ? NOP_WORD : {2'b10, 1'b1, 29'($urandom)};
        3, 4: w = 32'($urandom_range(0, 1023));
        default: w = $urandom;
      endcase
      cycle(w, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, acc);
    end
    idle(5, 1'b1);
    #5;
    chk("beats_left", 64'(beat_q.size()), 64'(0));
    chk("writes_left", 64'(wr_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
